// File: rtl/d_phy_transmitter.sv
// HS-only D-PHY transmitter: one data lane plus clock lane.
// A burst is clock pre-run, HS-zero, sync byte 8'h1D, payload (LSB first), trail and
// clock post-run. Bytes arrive over a valid/ready handshake taken only at byte boundaries.
module d_phy_transmitter #(
    parameter int unsigned T_CLK_PRE  = 8,
    parameter int unsigned T_HS_ZERO  = 16,
    parameter int unsigned T_HS_TRAIL = 8,
    parameter int unsigned T_CLK_POST = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       hs_enable,
    output logic       clock_lane,
    output logic       data_lane,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        StIdle,
        StClkPre,
        StHsZero,
        StSync,
        StData,
        StTrail,
        StClkPost
    } state_e;

    localparam logic [7:0] PreEnd   = 8'(T_CLK_PRE - 1);
    localparam logic [7:0] ZeroEnd  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] TrailEnd = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] PostEnd  = 8'(T_CLK_POST - 1);
    localparam logic [7:0] SyncByte = 8'h1D;

    state_e     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;      // byte now in the shifter was marked last
    logic       trail_q, trail_d;    // inverse of the final transmitted bit
    logic       clk_q, clk_d;
    logic       underrun_q, underrun_d;

    // State and datapath registers; reset clears every output source at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            phase_q    <= 8'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            last_q     <= 1'b0;
            trail_q    <= 1'b0;
            clk_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            trail_q    <= trail_d;
            clk_q      <= clk_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state, counters, shifter and the byte_ready handshake.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        last_d     = last_q;
        trail_d    = trail_q;
        clk_d      = ~clk_q;
        underrun_d = 1'b0;
        byte_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                clk_d   = 1'b0;
                phase_d = 8'd0;
                bit_d   = 3'd0;
                // The presented byte is left in place; it is taken at the sync boundary.
                if (byte_valid) begin
                    state_d = StClkPre;
                    clk_d   = 1'b1;
                end
            end
            StClkPre: begin
                phase_d = phase_q + 8'd1;
                if (phase_q == PreEnd) begin
                    phase_d = 8'd0;
                    state_d = StHsZero;
                end
            end
            StHsZero: begin
                phase_d = phase_q + 8'd1;
                if (phase_q == ZeroEnd) begin
                    phase_d = 8'd0;
                    bit_d   = 3'd0;
                    shift_d = SyncByte;
                    last_d  = 1'b0;
                    state_d = StSync;
                end
            end
            StSync, StData: begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    if (last_q) begin
                        trail_d = ~shift_q[0];
                        state_d = StTrail;
                    end else begin
                        byte_ready = 1'b1;
                        if (byte_valid) begin
                            shift_d = byte_data;
                            last_d  = byte_last;
                            state_d = StData;
                        end else begin
                            underrun_d = 1'b1;
                            trail_d    = ~shift_q[0];
                            state_d    = StTrail;
                        end
                    end
                end
            end
            StTrail: begin
                phase_d = phase_q + 8'd1;
                if (phase_q == TrailEnd) begin
                    phase_d = 8'd0;
                    state_d = StClkPost;
                end
            end
            StClkPost: begin
                phase_d = phase_q + 8'd1;
                if (phase_q == PostEnd) begin
                    phase_d = 8'd0;
                    clk_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                clk_d   = 1'b0;
            end
        endcase
    end

    // Lane outputs decoded from the registered state.
    always_comb begin
        data_lane = 1'b0;
        unique case (state_q)
            StSync, StData:     data_lane = shift_q[0];
            StTrail, StClkPost: data_lane = trail_q;
            default:            data_lane = 1'b0;
        endcase
    end

    assign hs_enable  = (state_q != StIdle);
    assign busy       = (state_q != StIdle);
    assign clock_lane = clk_q;
    assign underrun   = underrun_q;

endmodule

// File: doc/d_phy_transmitter.md
# d_phy_transmitter

HS-only D-PHY transmitter for a single data lane plus clock lane. It takes a byte stream over a valid/ready handshake and emits one HS burst. Each burst is clock-lane pre-run, HS-zero, sync byte, payload bytes LSB first, HS-trail, then clock-lane post-run. It sits at the bottom of the CSI-2 transmit path and feeds LVDS output buffers. It is the counterpart of the team's HS-only receiver and is compatible with it bit for bit.

## Interface
Parameters:
- T_CLK_PRE, 8: bit cycles of clock-lane toggling before HS-zero (1..255)
- T_HS_ZERO, 16: bit cycles of data lane held 0 before sync (1..255)
- T_HS_TRAIL, 8: bit cycles of trail after last payload bit (1..255)
- T_CLK_POST, 32: bit cycles of clock-lane toggling after trail (1..255, even)

Ports:
- clock  in  1  bit clock; one lane bit per cycle
- reset_n  in  1  asynchronous, active-low reset
- byte_data  in  8  payload byte
- byte_valid  in  1  byte_data/byte_last valid
- byte_last  in  1  this byte ends the burst
- byte_ready  out  1  byte accepted this cycle when byte_valid is also high
- hs_enable  out  1  enable for the LVDS output buffers; high for the whole burst
- clock_lane  out  1  DDR lane clock; toggles every cycle while hs_enable is high
- data_lane  out  1  serial HS data
- busy  out  1  state != IDLE
- underrun  out  1  one-cycle pulse when a byte boundary finds no valid byte

## Operation
- FSM states: IDLE, CLK_PRE, HS_ZERO, SYNC, DATA, TRAIL, CLK_POST. Uses an 8-bit phase counter and a 3-bit bit counter.
- IDLE:
  - All outputs are 0.
  - byte_valid=1 → CLK_PRE next cycle. The byte is not consumed; it stays presented.
- CLK_PRE:
  - hs_enable=1, clock_lane toggles, data_lane=0.
  - After T_CLK_PRE cycles → HS_ZERO.
- HS_ZERO:
  - data_lane=0 for T_HS_ZERO cycles → SYNC.
- SYNC:
  - Shifts out byte 8'h1D LSB first: bit sequence 1,0,1,1,1,0,0,0.
  - After 8 cycles → DATA.
- DATA:
  - Shift register outputs bit 0 first, one bit per cycle.
  - The next byte is loaded at each byte boundary.
- Byte boundary:
  - This is the last bit cycle of SYNC or of a payload byte (bit counter = 7).
  - byte_ready=1 in that cycle unless the current byte was marked byte_last.
  - If byte_valid=1, the byte is transferred and its bit 0 drives data_lane in the next cycle.
  - If byte_valid=0, underrun pulses in the next cycle and the FSM enters TRAIL. An underrun during SYNC sends zero payload bytes.
- byte_last:
  - After the last byte's 8 bits → TRAIL.
  - byte_ready stays low at that boundary.
- TRAIL:
  - data_lane = inverse of the final transmitted bit, held T_HS_TRAIL cycles → CLK_POST.
- CLK_POST:
  - data_lane holds the trail value and clock_lane keeps toggling.
  - After T_CLK_POST cycles → IDLE.
  - This run lets the receiver's synchronous reset land while its clock is still running.
- byte_ready is low in all states other than the boundary cycles above. byte_valid outside a boundary is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Asserting reset_n low mid-burst drops hs_enable, clock_lane and data_lane to 0 immediately. No trail is sent and any byte not yet accepted stays with the source.
- Burst start latency: byte_valid high in IDLE → hs_enable high on the next rising edge.
- clock_lane:
  - Goes 1 in the first CLK_PRE cycle, then inverts every cycle.
  - Forced to 0 on entry to IDLE.
  - The 90° clock/data skew is an I/O-level concern, not this block's.
- Burst length with N payload bytes, with hs_enable high: T_CLK_PRE + T_HS_ZERO + 8 + 8N + T_HS_TRAIL + T_CLK_POST cycles.
- A new burst requires a return to IDLE. Minimum gap between bursts is 1 cycle of hs_enable=0.
- Back-to-back payload has no bubble: byte k+1 bit 0 follows byte k bit 7 in the next cycle.

## Test plan
- Single byte 8'hA5 with last=1, default parameters:
  - hs_enable high for 8+16+8+8+8+32 = 80 cycles.
  - data_lane sequence: 16×0, then 1,0,1,1,1,0,0,0, then 1,0,1,0,0,1,0,1, then 8×0 trail (inverse of final 1).
- Three bytes 8'h01, 8'h02, 8'h03 (last on 8'h03), valid held high:
  - Exactly 3 ready pulses, 8 cycles apart.
  - 24 contiguous payload bits, no gaps, no underrun.
- Source drops valid after byte 8'h55 without last:
  - underrun pulses once at that boundary.
  - Trail value is 1 (the final bit of 8'h55 is 0); then CLK_POST; then IDLE.
- reset_n pulsed low during the 2nd payload byte:
  - All outputs read 0 immediately.
  - busy=0, and no ready pulse occurs until a new burst.
- Loopback into the HS receiver model, with its reset asserted during CLK_POST:
  - A burst of 16 random bytes is reproduced exactly, in order.
  - The receiver is idle (no enable) before the next burst.
- Parameters T_CLK_PRE=1, T_HS_ZERO=1, T_HS_TRAIL=1, T_CLK_POST=2, one byte:
  - Total hs_enable = 21 cycles.
  - clock_lane ends at 0 in IDLE.
